// File: rtl/sr_multi_ctrl.sv
// sr_multi_ctrl
//   Drives NCH configuration shift-register chains in parallel from one shared
//   clk_sr/load_sr pair. Each chain is shifted WIDTH bits (plus READ_DELAY
//   padding pulses). The chip readback is captured on each clk_sr falling
//   edge, and dout/mismatch are presented with a one-cycle valid pulse.
//
//   Ports
//     clk_in, rst    system clock, asynchronous active-high reset
//     pulse_in       start request (rising edge; ignored while busy)
//     din            write words, channel c at din[c*WIDTH +: WIDTH]
//     div            clk_sr half-period minus 1, in clk_in cycles
//     data_in        serial readback, one bit per chain
//     clk_sr         shift clock to the chip
//     data_out       serial write data, one bit per chain
//     load_sr        latch strobe to the chip (2 half-periods wide)
//     dout           captured readback words
//     valid          one-cycle pulse; dout/mismatch are updated in this cycle
//     busy           high from operation start until valid
//     mismatch       per-channel readback != written word
//
//   Optional build macro: SR_READBACK_CHECK_EN
//     defined   -> per-channel readback comparator; mismatch registered at valid
//     undefined -> no comparator is built; mismatch is tied to 0
module sr_multi_ctrl #(
    parameter int WIDTH           = 170,
    parameter int NCH             = 2,
    parameter int CNT_WIDTH       = 8,
    parameter int DIV_WIDTH       = 6,
    parameter int SHIFT_DIRECTION = 1,
    parameter int READ_DELAY      = 0
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 pulse_in,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [NCH-1:0]       data_in,
    output logic                 clk_sr,
    output logic [NCH-1:0]       data_out,
    output logic                 load_sr,
    output logic [NCH*WIDTH-1:0] dout,
    output logic                 valid,
    output logic                 busy,
    output logic [NCH-1:0]       mismatch
);
    localparam int N = WIDTH + READ_DELAY;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} state_t;
    state_t r_state, w_state_nxt;

    logic                            r_pulse_d;
    logic [DIV_WIDTH-1:0]            r_div;
    // Half-period counter in SHIFT; reused to time the 2H-cycle load window.
    logic [DIV_WIDTH:0]              r_hcnt;
    logic [CNT_WIDTH-1:0]            r_bitcnt;
    logic                            r_clk_sr, r_load_sr, r_valid, r_busy;
    // Transmit shifter: its output end drives data_out directly, and it is
    // zero outside SHIFT, so data_out is glitch-free and 0 when idle.
    logic [NCH-1:0][WIDTH-1:0]       r_tx, r_rx;
    logic [NCH*WIDTH-1:0]            r_dout;
    logic [NCH-1:0][WIDTH-1:0]       w_tx_sh, w_rx_sh;
    logic w_start, w_half, w_fall, w_last, w_load_end, w_keep;

    always_comb begin
        w_start     = pulse_in & ~r_pulse_d;
        w_half      = (r_hcnt == {1'b0, r_div});
        w_fall      = w_half & r_clk_sr;
        w_last      = (r_bitcnt == CNT_WIDTH'(N - 1));
        w_load_end  = (r_hcnt == {r_div, 1'b1});   // 2H-1
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)          w_state_nxt = SHIFT;
            SHIFT:   if (w_fall && w_last) w_state_nxt = LOAD;
            LOAD:    if (w_load_end)       w_state_nxt = DONE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // The first READ_DELAY samples are chip latency and are dropped.
    if (READ_DELAY == 0) begin : g_keep_all
        assign w_keep = 1'b1;
    end else begin : g_keep_late
        assign w_keep = (r_bitcnt >= CNT_WIDTH'(READ_DELAY));
    end

    if (SHIFT_DIRECTION != 0) begin : g_msb_first
        always_comb begin
            for (int c = 0; c < NCH; c++) begin
                data_out[c] = r_tx[c][WIDTH-1];
                w_tx_sh[c]  = {r_tx[c][WIDTH-2:0], 1'b0};
                w_rx_sh[c]  = {r_rx[c][WIDTH-2:0], data_in[c]};
            end
        end
    end else begin : g_lsb_first
        always_comb begin
            for (int c = 0; c < NCH; c++) begin
                data_out[c] = r_tx[c][0];
                w_tx_sh[c]  = {1'b0, r_tx[c][WIDTH-1:1]};
                w_rx_sh[c]  = {data_in[c], r_rx[c][WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pulse_d <= 1'b0;
            r_div     <= '0;
            r_hcnt    <= '0;
            r_bitcnt  <= '0;
            r_clk_sr  <= 1'b0;
            r_load_sr <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_dout    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pulse_d <= pulse_in;
            r_busy    <= (w_state_nxt == SHIFT) || (w_state_nxt == LOAD);
            r_load_sr <= (w_state_nxt == LOAD);
            r_valid   <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: if (w_start) begin
                    r_tx     <= din;
                    r_div    <= div;
                    r_hcnt   <= '0;
                    r_bitcnt <= '0;
                    r_clk_sr <= 1'b0;
                end
                SHIFT: begin
                    if (w_half) begin
                        r_hcnt   <= '0;
                        r_clk_sr <= ~r_clk_sr;
                        if (r_clk_sr) begin
                            // Falling edge: sample readback, then advance data.
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_tx     <= w_last ? '0 : w_tx_sh;
                            if (w_keep) r_rx <= w_rx_sh;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                LOAD:    r_hcnt <= r_hcnt + 1'b1;
                default: ;
            endcase
            if (w_state_nxt == DONE) r_dout <= r_rx;
        end
    end

`ifdef SR_READBACK_CHECK_EN
    logic [NCH-1:0][WIDTH-1:0] r_din;
    logic [NCH-1:0]            r_mismatch;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_din      <= '0;
            r_mismatch <= '0;
        end else begin
            if (r_state == IDLE && w_start) r_din <= din;
            if (w_state_nxt == DONE)
                for (int c = 0; c < NCH; c++) r_mismatch[c] <= (r_rx[c] != r_din[c]);
        end
    end
    assign mismatch = r_mismatch;
`else
    assign mismatch = '0;
`endif

    assign clk_sr  = r_clk_sr;
    assign load_sr = r_load_sr;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign dout    = r_dout;
endmodule
